ten_g_eth_tx_port_arbiter: RTL and testbench

Parametrised N-port, frame-level round-robin arbiter that merges several user AXI-Stream TX sources onto the single `tx_axis_fifo_*` interface of one 10G MAC port. It sits between switch-side egress queues and the MAC wrapper, in the MAC user clock domain. It never interleaves frames: a granted port owns the output until its `tlast` beat is accepted. A 2-entry output FIFO decouples upstream `tready` from downstream `m_tready`.

---
 rtl/ten_g_eth_tx_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ten_g_eth_tx_port_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ten_g_eth_tx_port_arbiter.sv
// ten_g_eth_tx_port_arbiter
// Frame-level round-robin arbiter that merges NUM_PORTS AXI-Stream TX sources
// onto a single 10G MAC tx_axis_fifo interface. A granted port keeps the
// output until its tlast beat is accepted. A 2-entry FIFO sits on the output
// so upstream s_tready depends only on registered state.
// Optional feature macro: TENG_ARB_STATS_EN builds saturating per-port frame
// counters. Without it, frame_cnt is tied to zero.

module ten_g_eth_tx_port_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_W    = 64,
  parameter  int CNT_W     = 32,
  localparam int KEEP_W    = DATA_W / 8,
  localparam int GNT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        user_clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]        s_tvalid,
  input  logic [NUM_PORTS-1:0]        s_tlast,
  output logic [NUM_PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [KEEP_W-1:0]           m_tkeep,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  input  logic                        m_tready,
  output logic [GNT_W-1:0]            grant_port,
  output logic                        busy,
  output logic [NUM_PORTS*CNT_W-1:0]  frame_cnt
);

  typedef enum logic [0:0] {
    IDLE,
    XFER
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [GNT_W-1:0]   last_grant;
  logic [GNT_W-1:0]   next_grant;

  logic               req_found;
  logic [GNT_W-1:0]   req_idx;

  logic [DATA_W-1:0]  sel_data;
  logic [KEEP_W-1:0]  sel_keep;
  logic               sel_valid;
  logic               sel_last;

  logic               push;
  logic               pop;
  logic [1:0]         fifo_count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [DATA_W-1:0]  fifo_data [2];
  logic [KEEP_W-1:0]  fifo_keep [2];
  logic               fifo_last [2];

  // Select the granted port's stream signals with constant slices per port.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (last_grant == GNT_W'(i)) begin
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
        sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  // Round-robin search: first requester above last_grant, then wrap to the bottom.
  always_comb begin
    req_found = 1'b0;
    req_idx   = last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_found && s_tvalid[i] && (i > int'(last_grant))) begin
        req_found = 1'b1;
        req_idx   = GNT_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!req_found && s_tvalid[i] && (i <= int'(last_grant))) begin
        req_found = 1'b1;
        req_idx   = GNT_W'(i);
      end
    end
  end

  // Next-state, grant update and upstream ready; s_tready uses only registered state.
  always_comb begin
    next_state = state;
    next_grant = last_grant;
    s_tready   = '0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (req_found) begin
          next_state = XFER;
          next_grant = req_idx;
        end
      end
      XFER: begin
        if (fifo_count != 2'd2) begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (last_grant == GNT_W'(i)) begin
              s_tready[i] = 1'b1;
            end
          end
        end
        push = sel_valid && (fifo_count != 2'd2);
        if (push && sel_last) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state and grant registers; port 0 wins first after reset.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_W'(NUM_PORTS - 1);
    end else begin
      state      <= next_state;
      last_grant <= next_grant;
    end
  end

  assign pop = (fifo_count != 2'd0) && m_tready;

  // Two-entry output FIFO; simultaneous push and pop keep the count unchanged.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      fifo_count <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_keep[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= sel_data;
        fifo_keep[wr_ptr] <= sel_keep;
        fifo_last[wr_ptr] <= sel_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_tdata    = fifo_data[rd_ptr];
  assign m_tkeep    = fifo_keep[rd_ptr];
  assign m_tlast    = fifo_last[rd_ptr];
  assign m_tvalid   = (fifo_count != 2'd0);
  assign busy       = (state == XFER);
  assign grant_port = last_grant;

`ifdef TENG_ARB_STATS_EN
  logic [NUM_PORTS*CNT_W-1:0] frame_cnt_q;

  // Count accepted tlast beats per port, saturating at all-ones.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (push && sel_last) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((last_grant == GNT_W'(i)) &&
            (frame_cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          frame_cnt_q[i*CNT_W +: CNT_W] <= frame_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_ten_g_eth_tx_port_arbiter.sv
// tb_ten_g_eth_tx_port_arbiter
// Self-checking bench: an arbitration vector table plus hand-written
// sequences for fairness, backpressure, mid-frame reset and frame counters.
// Expected beats go into a scoreboard queue and are compared on output handshakes.

module tb_ten_g_eth_tx_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int CW = 4;
  localparam int GW = 2;

  logic              user_clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [GW-1:0]     grant_port;
  logic              busy;
  logic [NP*CW-1:0]  frame_cnt;

  ten_g_eth_tx_port_arbiter #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .CNT_W     (CW)
  ) dut (
    .user_clk   (user_clk),
    .reset      (reset),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .grant_port (grant_port),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [NP-1:0] mask;
    int            nbeats;
    logic [GW-1:0] exp_grant;
    logic [NP-1:0] exp_ready;
  } arb_vec_t;

  beat_t     exp_q[$];
  arb_vec_t  vecs[9];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last = NP - 1;
  int out_first_cyc = -1;
  int out_last_cyc = -1;
  int pop_count = 0;

  logic [NP-1:0] samp_ready;
  logic          samp_busy;
  logic [GW-1:0] samp_grant;
  logic          samp_mvalid;
  logic [DW-1:0] samp_mdata;
  logic [NP-1:0] in_hs;

  function automatic logic [DW-1:0] make_data(input int p, input int f, input int b);
    return {8'hA5, 8'(p), 16'(f), 16'(b), 16'hC0DE};
  endfunction

  function automatic logic [KW-1:0] make_keep(input logic last);
    return last ? 8'h3F : 8'hFF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: cycle budget expired", name);
  endtask

  task automatic pushBeat(input int p, input int f, input int b, input int nbeats);
    beat_t e;
    e.data = make_data(p, f, b);
    e.last = (b == nbeats - 1);
    e.keep = make_keep(e.last);
    exp_q.push_back(e);
  endtask

  // One clock: sample at negedge, score output handshakes, return just after posedge.
  task automatic tick();
    beat_t e;
    @(negedge user_clk);
    samp_ready  = s_tready;
    samp_busy   = busy;
    samp_grant  = grant_port;
    samp_mvalid = m_tvalid;
    samp_mdata  = m_tdata;
    in_hs       = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      pop_count++;
      if (out_first_cyc < 0) out_first_cyc = cyc;
      if (m_tlast) out_last_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("m_tdata", 64'(m_tdata), 64'(e.data));
        checkOutput("m_tkeep", 64'(m_tkeep), 64'(e.keep));
        checkOutput("m_tlast", 64'(m_tlast), 64'(e.last));
      end
    end
    cyc++;
    @(posedge user_clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_last = NP - 1;
  endtask

  task automatic drain();
    int k = 0;
    s_tvalid = '0;
    m_tready = 1'b1;
    while (exp_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    tick();
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Send one frame on port p; other mask ports request only in the arbitration cycle.
  task automatic applyStimulus(input logic [NP-1:0] mask, input int p, input int f, input int nbeats,
                               output logic [GW-1:0] g, output logic [NP-1:0] rdy,
                               output int first_rel, output int last_rel);
    int start = cyc;
    int b = 0;
    int pushed = 0;
    int budget = 0;
    g = '0;
    rdy = '0;
    first_rel = -1;
    last_rel = -1;
    while (b < nbeats && budget < 50) begin
      if (pushed == b) begin
        pushBeat(p, f, b, nbeats);
        pushed++;
      end
      s_tvalid = '0;
      s_tlast  = '0;
      for (int q = 0; q < NP; q++) begin
        s_tdata[q*DW +: DW] = make_data(q, f, 0);
        s_tkeep[q*KW +: KW] = 8'hFF;
      end
      if (cyc == start) s_tvalid = mask;
      s_tvalid[p] = 1'b1;
      s_tdata[p*DW +: DW] = make_data(p, f, b);
      s_tkeep[p*KW +: KW] = make_keep(b == nbeats - 1);
      s_tlast[p] = (b == nbeats - 1);
      tick();
      if (cyc - 1 == start + 1) begin
        g = samp_grant;
        rdy = samp_ready;
      end
      if (in_hs[p]) begin
        if (first_rel < 0) first_rel = cyc - 1 - start;
        if (b == nbeats - 1) last_rel = cyc - 1 - start;
        b++;
      end
      budget++;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    if (b < nbeats) timeoutFail("frame_timeout");
    model_last = p;
  endtask

  // All mask ports stream `frames` frames concurrently; m_tready low in a window.
  task automatic runMulti(input logic [NP-1:0] mask, input int frames, input int nbeats,
                          input int hold_start, input int hold_len,
                          output int last_rel, output logic stable,
                          output logic [NP-1:0] hold_ready, output logic hold_valid,
                          output logic [DW-1:0] hold_data);
    int left[NP];
    int bi[NP];
    int fi[NP];
    int ml = model_last;
    int total = 0;
    int start;
    int rel;
    int budget = 0;
    bit active;
    last_rel = -1;
    stable = 1'b1;
    hold_ready = '1;
    hold_valid = 1'b0;
    hold_data = '0;
    for (int q = 0; q < NP; q++) begin
      left[q] = mask[q] ? frames : 0;
      bi[q] = 0;
      fi[q] = 0;
      total += left[q];
    end
    // Reference round-robin order for the whole burst.
    for (int n = 0; n < total; n++) begin
      for (int k = 1; k <= NP; k++) begin
        int q = (ml + k) % NP;
        if (left[q] > 0) begin
          for (int b = 0; b < nbeats; b++) pushBeat(q, fi[q], b, nbeats);
          fi[q]++;
          left[q]--;
          ml = q;
          break;
        end
      end
    end
    for (int q = 0; q < NP; q++) begin
      left[q] = mask[q] ? frames : 0;
      fi[q] = 0;
    end
    start = cyc;
    active = 1'b1;
    while (active && budget < 400) begin
      s_tvalid = '0;
      s_tlast  = '0;
      for (int q = 0; q < NP; q++) begin
        s_tdata[q*DW +: DW] = make_data(q, fi[q], bi[q]);
        s_tkeep[q*KW +: KW] = make_keep(bi[q] == nbeats - 1);
        if (left[q] > 0) begin
          s_tvalid[q] = 1'b1;
          s_tlast[q]  = (bi[q] == nbeats - 1);
        end
      end
      rel = cyc - start;
      m_tready = !(rel >= hold_start && rel < hold_start + hold_len);
      tick();
      if (rel >= hold_start && rel < hold_start + hold_len) begin
        if (rel == hold_start) hold_data = samp_mdata;
        else if (samp_mdata !== hold_data) stable = 1'b0;
        if (rel == hold_start + hold_len - 1) begin
          hold_ready = samp_ready;
          hold_valid = samp_mvalid;
        end
      end
      active = 1'b0;
      for (int q = 0; q < NP; q++) begin
        if (in_hs[q] && left[q] > 0) begin
          if (bi[q] == nbeats - 1) begin
            bi[q] = 0;
            fi[q]++;
            left[q]--;
            last_rel = rel;
          end else begin
            bi[q]++;
          end
        end
        if (left[q] > 0) active = 1'b1;
      end
      budget++;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    if (active) timeoutFail("multi_timeout");
    model_last = ml;
  endtask

  initial begin
    logic [GW-1:0] g;
    logic [NP-1:0] rdy;
    logic [NP-1:0] hready;
    logic          hvalid;
    logic          hstable;
    logic [DW-1:0] hdata;
    int first_rel;
    int last_rel;
    int start;
    int hs;
    int k;
    int pops_before;
    logic [CW-1:0] exp_cnt3;
    logic [CW-1:0] exp_cnt17;

    vecs[0] = '{mask: 4'b1111, nbeats: 2, exp_grant: 2'd3, exp_ready: 4'b1000};
    vecs[1] = '{mask: 4'b1111, nbeats: 1, exp_grant: 2'd0, exp_ready: 4'b0001};
    vecs[2] = '{mask: 4'b0110, nbeats: 3, exp_grant: 2'd1, exp_ready: 4'b0010};
    vecs[3] = '{mask: 4'b0110, nbeats: 2, exp_grant: 2'd2, exp_ready: 4'b0100};
    vecs[4] = '{mask: 4'b0001, nbeats: 1, exp_grant: 2'd0, exp_ready: 4'b0001};
    vecs[5] = '{mask: 4'b1010, nbeats: 2, exp_grant: 2'd1, exp_ready: 4'b0010};
    vecs[6] = '{mask: 4'b1010, nbeats: 3, exp_grant: 2'd3, exp_ready: 4'b1000};
    vecs[7] = '{mask: 4'b1000, nbeats: 1, exp_grant: 2'd3, exp_ready: 4'b1000};
    vecs[8] = '{mask: 4'b0101, nbeats: 2, exp_grant: 2'd0, exp_ready: 4'b0001};

`ifdef TENG_ARB_STATS_EN
    exp_cnt3  = 4'd3;
    exp_cnt17 = 4'd15;
`else
    exp_cnt3  = 4'd0;
    exp_cnt17 = 4'd0;
`endif

    reset    = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;

    // Reset values
    doReset();
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_s_tready", 64'(s_tready), 64'd0);
    checkOutput("rst_m_tdata", 64'(m_tdata), 64'd0);
    checkOutput("rst_m_tkeep", 64'(m_tkeep), 64'd0);
    checkOutput("rst_grant_port", 64'(grant_port), 64'd3);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);

    // Single port 2, 3-beat frame, latency checks
    out_first_cyc = -1;
    out_last_cyc = -1;
    start = cyc;
    applyStimulus(4'b0100, 2, 1, 3, g, rdy, first_rel, last_rel);
    checkOutput("single_grant", 64'(g), 64'd2);
    checkOutput("single_ready", 64'(rdy), 64'b0100);
    checkOutput("single_first_in", 64'(first_rel), 64'd1);
    checkOutput("single_last_in", 64'(last_rel), 64'd3);
    drain();
    checkOutput("single_first_out", 64'(out_first_cyc - start), 64'd2);
    checkOutput("single_tlast_out", 64'(out_last_cyc - start), 64'd4);

    // Arbitration table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].mask, int'(vecs[i].exp_grant), 10 + i, vecs[i].nbeats, g, rdy, first_rel, last_rel);
      checkOutput($sformatf("vec%0d_grant", i), 64'(g), 64'(vecs[i].exp_grant));
      checkOutput($sformatf("vec%0d_ready", i), 64'(rdy), 64'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d_latency", i), 64'(first_rel), 64'd1);
      checkOutput($sformatf("vec%0d_span", i), 64'(last_rel - first_rel), 64'(vecs[i].nbeats - 1));
    end
    drain();

    // Fairness: all ports, two 2-beat frames each, one gap cycle per frame
    doReset();
    runMulti(4'b1111, 2, 2, 0, 0, last_rel, hstable, hready, hvalid, hdata);
    checkOutput("fair_last_accept", 64'(last_rel), 64'd23);
    drain();

    // Backpressure: m_tready low for 5 cycles mid-frame on port 1
    pops_before = pop_count;
    runMulti(4'b0010, 1, 6, 3, 5, last_rel, hstable, hready, hvalid, hdata);
    checkOutput("bp_ready_low", 64'(hready), 64'd0);
    checkOutput("bp_valid_held", 64'(hvalid), 64'd1);
    checkOutput("bp_data_stable", 64'(hstable), 64'd1);
    checkOutput("bp_hold_data", 64'(hdata), 64'(make_data(1, 0, 1)));
    drain();
    checkOutput("bp_beat_count", 64'(pop_count - pops_before), 64'd6);

    // Mid-frame reset on beat 2 of a 4-beat frame from port 0
    hs = 0;
    k = 0;
    pushBeat(0, 40, 0, 4);
    while (hs < 2 && k < 20) begin
      s_tvalid = 4'b0001;
      s_tlast  = '0;
      s_tdata[0 +: DW] = make_data(0, 40, hs);
      s_tkeep[0 +: KW] = make_keep(1'b0);
      tick();
      if (in_hs[0]) begin
        hs++;
        if (hs < 2) pushBeat(0, 40, hs, 4);
      end
      k++;
    end
    if (hs < 2) timeoutFail("midrst_timeout");
    s_tdata[0 +: DW] = make_data(0, 40, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_tvalid = '0;
    exp_q.delete();
    model_last = NP - 1;
    tick();
    checkOutput("midrst_m_tvalid", 64'(samp_mvalid), 64'd0);
    checkOutput("midrst_busy", 64'(samp_busy), 64'd0);
    checkOutput("midrst_grant", 64'(samp_grant), 64'd3);
    checkOutput("midrst_s_tready", 64'(samp_ready), 64'd0);
    applyStimulus(4'b0010, 1, 41, 2, g, rdy, first_rel, last_rel);
    checkOutput("postrst_grant", 64'(g), 64'd1);
    checkOutput("postrst_ready", 64'(rdy), 64'b0010);
    drain();

    // Frame counters: 17 single-beat frames on port 0
    doReset();
    for (int n = 0; n < 17; n++) begin
      applyStimulus(4'b0001, 0, 50 + n, 1, g, rdy, first_rel, last_rel);
      if (n == 2) checkOutput("cnt0_after3", 64'(frame_cnt[0 +: CW]), 64'(exp_cnt3));
    end
    drain();
    checkOutput("cnt0_saturated", 64'(frame_cnt[0 +: CW]), 64'(exp_cnt17));
    checkOutput("cnt_others_zero", 64'(frame_cnt[NP*CW-1:CW]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
